// File: rtl/inst_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package inst_mem_responder_pkg;

    // Control modes: SERVE accepts fetches, LOAD owns the memory for program writes.
    typedef enum logic {
        SERVE = 1'b0,
        LOAD  = 1'b1
    } state_e;

    // Instructions are 32-bit words, so the low two byte-address bits select nothing.
    localparam int WORD_OFFSET = 2;

    // Data value returned alongside a fault response.
    localparam int unsigned FAULT_WORD = 0;

endpackage

// File: rtl/inst_mem_responder_rsp_fifo.sv
// Two-entry response FIFO holding {err, data} in acceptance order.
module rsp_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] store [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Pointer and occupancy tracking; flush drops everything buffered.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset is needed.
    // NOTE: data storage is deliberately left unreset; valid-tracking flops guard its use.
    always_ff @(posedge clk) begin
        if (push && !flush) store[wr_ptr] <= push_data;
    end

    assign head_data = store[rd_ptr];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory with a one-cycle registered read, a two-entry response
// buffer, program-load writes and flush support for PC reloads.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int NO_BITS = 32,
    parameter int DEPTH   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [NO_BITS-1:0] req_addr,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [NO_BITS-1:0] rsp_data,
    output logic               rsp_err,
    input  logic               rsp_ready,
    input  logic               flush,
    input  logic               prog_we,
    input  logic [NO_BITS-1:0] prog_addr,
    input  logic [NO_BITS-1:0] prog_data
);

    localparam int               IDX_W     = NO_BITS - WORD_OFFSET;
    localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    logic [NO_BITS-1:0] mem [DEPTH];

    state_e             state_q;
    state_e             state_d;
    logic               fetch_en;
    logic               inflight_q;
    logic               accept;
    logic               pop;
    logic               req_ok;
    logic               prog_ok;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   prog_idx;
    logic [NO_BITS:0]   rd_q;
    logic [NO_BITS:0]   head;
    logic [1:0]         fifo_count;
    logic [2:0]         occupancy;

    // Address decode: word index plus alignment and range qualification.
    assign req_idx  = req_addr[NO_BITS-1:WORD_OFFSET];
    assign prog_idx = prog_addr[NO_BITS-1:WORD_OFFSET];
    assign req_ok   = (req_addr[WORD_OFFSET-1:0] == '0) && (req_idx < DEPTH_IDX);
    assign prog_ok  = (prog_addr[WORD_OFFSET-1:0] == '0) && (prog_idx < DEPTH_IDX);

    // Mode register: LOAD tracks prog_we, SERVE otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SERVE;
        else      state_q <= state_d;
    end

    // Next-mode logic; fetches are enabled only when the coming mode is SERVE.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SERVE:   if (prog_we)  state_d = LOAD;
            LOAD:    if (!prog_we) state_d = SERVE;
            default: state_d = SERVE;
        endcase
        fetch_en = (state_d == SERVE);
    end

    // Handshake: a slot is free if fewer than two responses are owed, or one leaves now.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = rst && fetch_en && !flush && ((occupancy < 3'd2) || pop);
    assign accept    = req_valid && req_ready;

    // In-flight flag: set for the single cycle between acceptance and FIFO push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       inflight_q <= 1'b0;
        else if (flush) inflight_q <= 1'b0;
        else            inflight_q <= accept;
    end

    // Memory write port and registered read; faults skip the array entirely.
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) mem[prog_idx[AW-1:0]] <= prog_data;
        if (accept) begin
            if (req_ok) rd_q <= {1'b0, mem[req_idx[AW-1:0]]};
            else        rd_q <= {1'b1, NO_BITS'(FAULT_WORD)};
        end
    end

    rsp_fifo #(
        .W (NO_BITS + 1)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (inflight_q),
        .push_data (rd_q),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    // Head response is forced to zero whenever nothing is buffered.
    assign rsp_valid           = (fifo_count != 2'd0);
    assign {rsp_err, rsp_data} = rsp_valid ? head : '0;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder with hand-computed expected values.
module tb_inst_mem_responder;

    localparam int NO_BITS = 32;
    localparam int DEPTH   = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic [NO_BITS-1:0] req_addr;
    logic               req_ready;
    logic               rsp_valid;
    logic [NO_BITS-1:0] rsp_data;
    logic               rsp_err;
    logic               rsp_ready;
    logic               flush;
    logic               prog_we;
    logic [NO_BITS-1:0] prog_addr;
    logic [NO_BITS-1:0] prog_data;

    int n_cmp = 0;
    int n_bad = 0;

    inst_mem_responder #(
        .NO_BITS (NO_BITS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [NO_BITS-1:0] a, input logic [NO_BITS-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    logic [NO_BITS-1:0] exp_stream [4];

    initial begin
        exp_stream[0] = 32'h11;
        exp_stream[1] = 32'h22;
        exp_stream[2] = 32'h33;
        exp_stream[3] = 32'h44;

        rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        #3;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        step(); step();
        rst = 1'b1;
        #1;
        check("post_reset_req_ready", req_ready, 1);

        // Program load, including two writes that must be ignored.
        prog(32'h0, 32'h11);
        prog(32'h4, 32'h22);
        prog(32'h8, 32'h33);
        prog(32'hC, 32'h44);
        prog(32'h2, 32'hDEAD);
        prog(32'h100, 32'hBEEF);

        // Streaming fetch with consumer always ready.
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_valid = (i < 4);
            req_addr  = 32'(4 * i);
            #1;
            if (i < 4) check($sformatf("stream_ready_%0d", i), req_ready, 1);
            if (i >= 2 && i <= 5) begin
                check($sformatf("stream_valid_%0d", i), rsp_valid, 1);
                check($sformatf("stream_data_%0d", i), rsp_data, exp_stream[i-2]);
                check($sformatf("stream_err_%0d", i), rsp_err, 0);
            end else begin
                check($sformatf("stream_idle_%0d", i), rsp_valid, 0);
            end
            step();
        end

        // Backpressure: two accepted, third stalls until the consumer pops.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8; #1;
        check("bp_ready_a", req_ready, 1);
        step();
        req_addr = 32'hC; #1;
        check("bp_ready_b", req_ready, 1);
        step();
        req_addr = 32'h4; #1;
        check("bp_ready_c_blocked", req_ready, 0);
        step(); #1;
        check("bp_ready_d_blocked", req_ready, 0);
        check("bp_head_d", rsp_data, 32'h33);
        step(); #1;
        check("bp_head_stable", rsp_data, 32'h33);
        rsp_ready = 1'b1; #1;
        check("bp_ready_on_pop", req_ready, 1);
        step();
        req_valid = 1'b0; #1;
        check("bp_order_2", rsp_data, 32'h44);
        step(); #1;
        check("bp_order_3", rsp_data, 32'h22);
        step(); #1;
        check("bp_drained", rsp_valid, 0);

        // Fault responses: misaligned and out-of-range.
        req_valid = 1'b1; req_addr = 32'h6;
        step();
        req_addr = 32'(4 * DEPTH);
        step();
        req_valid = 1'b0; #1;
        check("err_misaligned_valid", rsp_valid, 1);
        check("err_misaligned_err", rsp_err, 1);
        check("err_misaligned_data", rsp_data, 0);
        step(); #1;
        check("err_range_err", rsp_err, 1);
        check("err_range_data", rsp_data, 0);
        step(); #1;
        check("err_drained", rsp_valid, 0);

        // Flush with two buffered responses; a request in the flush cycle is refused.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        step(); #1;
        check("flush_pre_head", rsp_data, 32'h11);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'hC; #1;
        check("flush_req_ready", req_ready, 0);
        step();
        flush = 1'b0; req_valid = 1'b0; #1;
        check("flush_rsp_valid", rsp_valid, 0);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
        step();
        req_valid = 1'b0;
        step(); #1;
        check("flush_next_data", rsp_data, 32'h22);
        step(); #1;
        check("flush_drained", rsp_valid, 0);

        // Program write has priority over a concurrent fetch.
        prog_we = 1'b1; prog_addr = 32'h10; prog_data = 32'hCAFE_F00D;
        req_valid = 1'b1; req_addr = 32'h10; #1;
        check("prio_req_ready", req_ready, 0);
        step();
        prog_we = 1'b0; #1;
        check("prio_fetch_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        step(); #1;
        check("prio_new_data", rsp_data, 32'hCAFE_F00D);
        step(); #1;
        check("prio_drained", rsp_valid, 0);

        // Reset with one buffered response and one in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        req_valid = 1'b0; #1;
        check("rst_pre_head", rsp_data, 32'h11);
        rst = 1'b0; #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_req_ready", req_ready, 0);
        step(); step();
        rst = 1'b1;
        step(); #1;
        check("rst_after_release_a", rsp_valid, 0);
        step(); #1;
        check("rst_after_release_b", rsp_valid, 0);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
        step();
        req_valid = 1'b0;
        step(); #1;
        check("rst_mem_kept", rsp_data, 32'h44);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter NO_BITS, default 32, address and instruction width in bits.
REQ-002 Parameter DEPTH, default 64, number of instruction words stored.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  fetch request present (from PC side).
REQ-006 req_addr  input  NO_BITS  byte address of requested instruction.
REQ-007 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 rsp_valid  output  1  head response available.
REQ-009 rsp_data  output  NO_BITS  instruction word of head response.
REQ-010 rsp_err  output  1  head response is a fault (misaligned or out-of-range).
REQ-011 rsp_ready  input  1  consumer takes head response this cycle when high with rsp_valid.
REQ-012 flush  input  1  discard all in-flight and buffered responses (PC reload).
REQ-013 prog_we  input  1  program-load write strobe.
REQ-014 prog_addr  input  NO_BITS  byte address for program-load write.
REQ-015 prog_data  input  NO_BITS  instruction word to store.

Function
REQ-016 Word index SHALL be addr[NO_BITS-1:2]; a request is in range iff index < DEPTH.
REQ-017 Accepted request (req_valid && req_ready) at edge N SHALL produce its response entry at edge N+1 (one-cycle registered read, inflight flag set for that cycle).
REQ-018 Responses SHALL be buffered in a 2-entry FIFO and delivered in acceptance order.
REQ-019 req_ready SHALL equal !prog_we && !flush && ((count + inflight) < 2 || (rsp_valid && rsp_ready)), giving one fetch per cycle when consumer holds rsp_ready high.
REQ-020 rsp_valid SHALL equal (count != 0); rsp_data/rsp_err SHALL show the FIFO head and stay stable while rsp_valid && !rsp_ready.
REQ-021 Request with req_addr[1:0] != 0 or index >= DEPTH SHALL yield rsp_err=1, rsp_data=0, without reading memory.
REQ-022 Valid request SHALL yield rsp_err=0, rsp_data=mem[index].
REQ-023 prog_we SHALL write prog_data to mem[prog_addr[NO_BITS-1:2]] at the edge; writes with misaligned or out-of-range prog_addr SHALL be ignored.
REQ-024 prog_we SHALL have priority over fetch: no request accepted in a prog_we cycle; in-flight reads and buffered responses SHALL still complete.
REQ-025 flush at edge N SHALL clear count and inflight; any request presented at edge N SHALL NOT be accepted; rsp_valid SHALL be 0 after edge N.
REQ-026 Simultaneous push (inflight completion) and pop SHALL leave count unchanged; pop with count=0 SHALL be impossible (rsp_valid=0).
REQ-027 Control state SHALL be a 2-state machine: SERVE (fetch enabled) and LOAD (prog_we high); SERVE->LOAD when prog_we=1, LOAD->SERVE when prog_we=0.

Reset
REQ-028 rst=0 SHALL immediately clear count, inflight, FIFO pointers, and force state SERVE; rsp_valid=0, rsp_err=0, rsp_data=0, req_ready=0 during reset.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-transaction SHALL discard the in-flight request with no response after release.

Structure
REQ-031 Shared package SHALL hold the state enum (SERVE, LOAD), the word-offset constant (2), and the fault-word constant (0).
REQ-032 The 2-entry response FIFO SHALL be one sub-module, rsp_fifo, parameterised by NO_BITS+1 data width.

Verification
REQ-033 Load mem[0..3]=0x11,0x22,0x33,0x44; stream addrs 0,4,8,12 with rsp_ready=1 -> rsp_data 0x11..0x44 on 4 consecutive cycles starting one cycle after first acceptance.
REQ-034 Hold rsp_ready=0, issue 3 requests -> exactly 2 accepted, req_ready=0 thereafter; release rsp_ready -> third accepted, order preserved.
REQ-035 req_addr=0x6 and req_addr=4*DEPTH -> rsp_err=1, rsp_data=0 for each.
REQ-036 Two responses buffered, flush=1 one cycle -> rsp_valid=0 next cycle; next request to 0x4 returns 0x22.
REQ-037 prog_we=1 concurrent with req_valid=1 -> req_ready=0, write lands; next-cycle fetch of the written address returns new data.
REQ-038 rst=0 asserted with one request in flight -> outputs zero immediately; after release rsp_valid stays 0 until a new request.
